// File: rtl/reg_bank.sv
// reg_bank: multi-port register bank with one write port and two registered read ports.
//   Optional macro REG_BANK_BYPASS_EN enables write-through forwarding on same-address
//   read-during-write. When it is undefined, such a read returns the pre-write contents.
//   Ports:
//     clk      - single clock, all state updates on its rising edge
//     rst_n    - synchronous active-low reset
//     clear    - synchronous flush of all entries
//     we       - write enable
//     waddr    - write address
//     wdata    - write data
//     ra_addr  - read port A address
//     rb_addr  - read port B address
//     ra_data  - registered read port A data
//     rb_data  - registered read port B data
//     ra_valid - entry read on A has been written since the last reset or clear
//     rb_valid - entry read on B has been written since the last reset or clear
module reg_bank #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [WIDTH-1:0]  ra_data,
   output logic [WIDTH-1:0]  rb_data,
   output logic              ra_valid,
   output logic              rb_valid
);
   localparam int DEPTH = 2**ADDR_W;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic             ra_hit, rb_hit;
   logic [WIDTH-1:0] ra_next, rb_next;
   logic             ra_vnext, rb_vnext;
`ifdef REG_BANK_BYPASS_EN
   assign ra_hit = we && (ra_addr == waddr);
   assign rb_hit = we && (rb_addr == waddr);
`else
   assign ra_hit = 1'b0;
   assign rb_hit = 1'b0;
`endif
   // Invalid entries read as zero regardless of stored contents.
   always_comb begin
      ra_vnext = ra_hit | vld[ra_addr];
      rb_vnext = rb_hit | vld[rb_addr];
      ra_next  = ra_hit ? wdata : vld[ra_addr] ? mem[ra_addr] : '0;
      rb_next  = rb_hit ? wdata : vld[rb_addr] ? mem[rb_addr] : '0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         mem      <= '{default: '0};
         vld      <= '0;
         ra_data  <= '0;
         rb_data  <= '0;
         ra_valid <= 1'b0;
         rb_valid <= 1'b0;
      end else begin
         ra_data  <= ra_next;
         rb_data  <= rb_next;
         ra_valid <= ra_vnext;
         rb_valid <= rb_vnext;
         if (we) begin
            mem[waddr] <= wdata;
            vld[waddr] <= 1'b1;
         end
      end
   end
endmodule
